tft_ctrl: RTL and testbench
===========================

# tft_ctrl

- 480x272 RGB TFT timing controller.
- Generates the pixel-clock enable, the raw line/frame counters, the active-area coordinates `hcnt`/`vcnt`, and the `tft_de` window consumed by the pixel source.
- Latches the returned 16-bit RGB565 `data_in` onto the panel pins with aligned HS/VS/DE and a derived panel clock.
- Sits between the image/pattern generator and the LCD connector.

## Interface
Parameters:
- `CLK_DIV`, 5: clk50M cycles per pixel; legal range ≥ 4.
- `H_SYNC`, 41: HS low width, in pixels.
- `H_BACK`, 2: horizontal back porch.
- `H_DISP`, 480: active pixels per line.
- `H_FRONT`, 2: horizontal front porch.
- `V_SYNC`, 10: VS low width, in lines.
- `V_BACK`, 2: vertical back porch.
- `V_DISP`, 272: active lines.
- `V_FRONT`, 2: vertical front porch.

Ports:
- `clk50M` in 1: system clock. One clock only.
- `rst` in 1: asynchronous, active-high reset.
- `data_in` in 16: RGB565 pixel from the pixel source for the current `hcnt`/`vcnt`.
- `hcnt` out 10: active-area x coordinate (0..H_DISP-1), 0 outside the active area.
- `vcnt` out 10: active-area y coordinate (0..V_DISP-1), 0 outside the active area.
- `tft_de` out 1: current position is inside the active area (to the pixel source).
- `tft_clk` out 1: panel pixel clock.
- `tft_hs` out 1: panel HS, active low.
- `tft_vs` out 1: panel VS, active low.
- `tft_den` out 1: panel DE, aligned with `tft_rgb`.
- `tft_rgb` out 16: panel pixel data.
- `tft_bl` out 1: backlight enable.
- `frame_start` out 1: one-cycle pulse at each frame wrap.

## Operation
- `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_en` = (`div_cnt` == CLK_DIV-1).
- Raw counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1), 10 bits each.
  - H_TOTAL = sum of the four H parameters = 525. V_TOTAL = sum of the four V parameters = 286.
  - On `pix_en`, `h_cnt` increments. When `h_cnt` wraps, `v_cnt` increments. When both are at their maximum, both wrap to 0.
- Active window: `h_cnt` in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and `v_cnt` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- `hcnt`, `vcnt` and `tft_de` are registers, updated on the `pix_en` cycle to describe the position becoming current.
  - Inside the window: `hcnt` = `h_cnt`-(H_SYNC+H_BACK) and `vcnt` = `v_cnt`-(V_SYNC+V_BACK).
  - Outside the window: both are 0 and `tft_de` = 0.
- Panel output stage, loaded on `pix_en` only:
  - `tft_rgb` <= `tft_de` ? `data_in` : 0
  - `tft_den` <= `tft_de`
  - `tft_hs` <= !(`h_cnt` < H_SYNC)
  - `tft_vs` <= !(`v_cnt` < V_SYNC)
  - Each of these describes the position just ending.
- `tft_clk` is a flop. It is 1 during cycles where `div_cnt` ≥ CLK_DIV/2 (integer division), giving a rising edge mid-pixel while panel data is stable.
- `tft_bl` becomes 1 on the first clk50M edge after reset release and stays 1.
- `frame_start` is 1 for exactly the one clk50M cycle following the `pix_en` at which (`h_cnt`, `v_cnt`) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).

## Timing
- Reset values:
  - `div_cnt`, `h_cnt`, `v_cnt`, `hcnt`, `vcnt` = 0.
  - `tft_de`, `tft_den`, `tft_clk`, `tft_bl`, `frame_start` = 0.
  - `tft_rgb` = 0.
  - `tft_hs` = `tft_vs` = 1 (inactive).
- Reset asserted mid-frame clears everything immediately (asynchronous). After release, counting restarts at `div_cnt` = 0 and position (0,0).
- Pixel-source contract:
  - `hcnt`/`vcnt`/`tft_de` change on the clk50M edge where `div_cnt` becomes 0.
  - `data_in` is sampled at the end of the `div_cnt` == CLK_DIV-1 cycle, so the source may take up to CLK_DIV-1 clocks of latency (registered address plus ROM gives 2).
  - This latency budget is why CLK_DIV ≥ 4 is required.
- Panel latency:
  - Panel pins lag the internal position by exactly one pixel period (CLK_DIV clocks).
  - `tft_hs`/`tft_vs`/`tft_den`/`tft_rgb` change together, only at `div_cnt` 0 boundaries.
- Periods at default parameters:
  - Line = 525×5 = 2625 clk.
  - Frame = 286×2625 = 750750 clk.
  - HS low = 41×5 = 205 clk per line.
  - VS low = 10 lines = 26250 clk.
  - `tft_den` high = 480×5 = 2400 clk per active line, on 272 lines per frame.
- Simultaneous line wrap and frame wrap: handled by the same `pix_en`; `frame_start` fires once.

## Test plan
- Reset then release, checking at release:
  - All outputs at reset values.
  - `tft_bl` = 1 one cycle later.
  - After 5 clk, `tft_hs` = 0 and `tft_vs` = 0.
  - `tft_clk` toggles with period 5 clk (high for 3, low for 2).
- Run one line: `tft_hs` is low for 205 clk, then high for 2420 clk; 2625-clk period.
- Run one frame:
  - `frame_start` pulses exactly 750750 clk apart.
  - `tft_den` is high on exactly 272 lines of 480 pixels (130560 pixels).
  - `vcnt` spans 0..271 and `hcnt` spans 0..479.
- Model `data_in` = {6'b0, `hcnt`} delayed 2 clk. `tft_rgb` must read 0,1,…,479 on successive pixels of each active line, aligned to `tft_den`, and 0 outside it.
- Assert `rst` mid-active-line, at `hcnt` = 200 and `vcnt` = 100:
  - Outputs return to reset values in the same cycle.
  - After release, the first `frame_start` arrives 750750 clk later.
- CLK_DIV = 4 build: `data_in` with 3-clk latency is still captured correctly, and the frame is 600600 clk.

Source files
------------

// File: rtl/tft_ctrl.sv
// 480x272 RGB TFT timing controller: pixel-clock divider, raw line/frame counters,
// active-area coordinates for the pixel source and a one-pixel-delayed panel output stage.
module tft_ctrl #(
    parameter int CLK_DIV = 5,
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic [15:0] data_in,
    output logic [9:0]  hcnt,
    output logic [9:0]  vcnt,
    output logic        tft_de,
    output logic        tft_clk,
    output logic        tft_hs,
    output logic        tft_vs,
    output logic        tft_den,
    output logic [15:0] tft_rgb,
    output logic        tft_bl,
    output logic        frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    localparam logic [9:0] H_MAX   = 10'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [9:0] V_MAX   = 10'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_DISP);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_DISP);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic             de_q, de_d;
    logic             clk_q, clk_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             den_q, den_d;
    logic [15:0]      rgb_q, rgb_d;
    logic             bl_q, bl_d;
    logic             fs_q, fs_d;
    logic             pix_en_s;
    logic             act_next_s;

    assign pix_en_s = (div_cnt_q == DIV_MAX);

    // Next-state logic for the divider, raw counters, source-side position and panel stage
    always_comb begin
        div_cnt_d  = div_cnt_q;
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        de_d       = de_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        den_d      = den_q;
        rgb_d      = rgb_q;
        bl_d       = 1'b1;
        fs_d       = 1'b0;
        act_next_s = 1'b0;

        if (pix_en_s) begin
            div_cnt_d = DIV_ZERO;
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_MAX) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end

        // Position fields describe the pixel becoming current; panel fields the one ending.
        act_next_s = (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                     (v_cnt_d >= V_START) && (v_cnt_d < V_END);

        if (pix_en_s) begin
            de_d  = act_next_s;
            hcnt_d = act_next_s ? (h_cnt_d - H_START) : 10'd0;
            vcnt_d = act_next_s ? (v_cnt_d - V_START) : 10'd0;
            rgb_d = de_q ? data_in : 16'd0;
            den_d = de_q;
            hs_d  = !(h_cnt_q < H_SYNC_W);
            vs_d  = !(v_cnt_q < V_SYNC_W);
            fs_d  = (h_cnt_q == H_MAX) && (v_cnt_q == V_MAX);
        end else begin
            fs_d = 1'b0;
        end

        clk_d = (div_cnt_d >= DIV_HALF);
    end

    // State and output registers
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            div_cnt_q <= DIV_ZERO;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            de_q      <= 1'b0;
            clk_q     <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            den_q     <= 1'b0;
            rgb_q     <= 16'd0;
            bl_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            de_q      <= de_d;
            clk_q     <= clk_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            den_q     <= den_d;
            rgb_q     <= rgb_d;
            bl_q      <= bl_d;
            fs_q      <= fs_d;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign tft_de      = de_q;
    assign tft_clk     = clk_q;
    assign tft_hs      = hs_q;
    assign tft_vs      = vs_q;
    assign tft_den     = den_q;
    assign tft_rgb     = rgb_q;
    assign tft_bl      = bl_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tft_ctrl.sv
// Directed bench for tft_ctrl: a default-parameter instance for reset, clock and line timing,
// and a shrunken CLK_DIV=4 instance for whole-frame, latency and mid-frame reset behaviour.
module tb_tft_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance A: default parameters, pixel source latency 2 clk
    logic        rst_a;
    logic [15:0] din_a;
    logic [9:0]  hcnt_a, vcnt_a;
    logic        de_a, pclk_a, hs_a, vs_a, den_a, bl_a, fs_a;
    logic [15:0] rgb_a;
    logic [9:0]  a_d1, a_d2;

    tft_ctrl dut_a (
        .clk50M(clk), .rst(rst_a), .data_in(din_a),
        .hcnt(hcnt_a), .vcnt(vcnt_a), .tft_de(de_a), .tft_clk(pclk_a),
        .tft_hs(hs_a), .tft_vs(vs_a), .tft_den(den_a), .tft_rgb(rgb_a),
        .tft_bl(bl_a), .frame_start(fs_a)
    );

    // Instance B: CLK_DIV=4, 15x8 raster (frame = 4*15*8 = 480 clk), source latency 3 clk
    localparam int FRAME_B = 480;
    logic        rst_b;
    logic [15:0] din_b;
    logic [9:0]  hcnt_b, vcnt_b;
    logic        de_b, pclk_b, hs_b, vs_b, den_b, bl_b, fs_b;
    logic [15:0] rgb_b;
    logic [9:0]  b_d1, b_d2, b_d3;

    tft_ctrl #(
        .CLK_DIV(4), .H_SYNC(3), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
    ) dut_b (
        .clk50M(clk), .rst(rst_b), .data_in(din_b),
        .hcnt(hcnt_b), .vcnt(vcnt_b), .tft_de(de_b), .tft_clk(pclk_b),
        .tft_hs(hs_b), .tft_vs(vs_b), .tft_den(den_b), .tft_rgb(rgb_b),
        .tft_bl(bl_b), .frame_start(fs_b)
    );

    // Pixel-source models: data_in = {6'b0, hcnt} delayed by the source latency
    always @(posedge clk) begin
        a_d1 <= hcnt_a;
        a_d2 <= a_d1;
        b_d1 <= hcnt_b;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign din_a = {6'b0, a_d2};
    assign din_b = {6'b0, b_d3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_rst(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic de, input logic pc, input logic hs, input logic vs,
                           input logic den, input logic [15:0] rgb, input logic bl,
                           input logic fs);
        chk({tag, "_hcnt"}, 32'(h), 0);
        chk({tag, "_vcnt"}, 32'(v), 0);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_clk"}, 32'(pc), 0);
        chk({tag, "_hs"}, 32'(hs), 1);
        chk({tag, "_vs"}, 32'(vs), 1);
        chk({tag, "_den"}, 32'(den), 0);
        chk({tag, "_rgb"}, 32'(rgb), 0);
        chk({tag, "_bl"}, 32'(bl), 0);
        chk({tag, "_fs"}, 32'(fs), 0);
    endtask

    initial begin
        int cnt;
        int den_cyc;
        int max_h;
        int max_v;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst("rst_a", hcnt_a, vcnt_a, de_a, pclk_a, hs_a, vs_a, den_a, rgb_a, bl_a, fs_a);
        chk_rst("rst_b", hcnt_b, vcnt_b, de_b, pclk_b, hs_b, vs_b, den_b, rgb_b, bl_b, fs_b);

        // ---- Instance A: release, backlight, pixel clock shape, first sync edges
        rst_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("bl_after_release", 32'(bl_a), 1);
            if (k == 4) chk("hs_before_pix", 32'(hs_a), 1);
            if (k == 5) begin
                chk("hs_after_5clk", 32'(hs_a), 0);
                chk("vs_after_5clk", 32'(vs_a), 0);
            end
            chk("tft_clk_shape", 32'(pclk_a), ((k % 5) >= 2) ? 1 : 0);
        end

        // ---- Instance A: HS high/low widths within a line
        cnt = 0;
        while (hs_a !== 1'b1 && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("hs_rise_seen", 32'(cnt < 5000), 1);
        cnt = 0;
        while (hs_a === 1'b1 && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("hs_high_width", cnt, 2420);
        cnt = 0;
        while (hs_a === 1'b0 && cnt < 5000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("hs_low_width", cnt, 205);

        // ---- Instance A: first active line, rgb carries hcnt with 2-clk source latency
        cnt = 0;
        while (den_a !== 1'b1 && cnt < 40000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("den_a_rise_seen", 32'(cnt < 40000), 1);
        chk("a_hcnt_at_den_rise", 32'(hcnt_a), 1);
        chk("a_vcnt_at_den_rise", 32'(vcnt_a), 0);
        chk("a_de_at_den_rise", 32'(de_a), 1);
        chk("a_hs_in_active", 32'(hs_a), 1);
        chk("a_vs_in_active", 32'(vs_a), 1);
        for (int i = 0; i < 480; i++) begin
            chk("a_rgb_pixel", 32'(rgb_a), i);
            chk("a_den_pixel", 32'(den_a), 1);
            repeat (5) @(posedge clk);
            #1;
        end
        chk("a_den_after_line", 32'(den_a), 0);
        chk("a_rgb_after_line", 32'(rgb_a), 0);

        // ---- Instance B: first frame_start after release
        @(negedge clk);
        rst_b = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (fs_b !== 1'b1 && cnt < 2000);
        chk("b_first_frame_start", cnt, FRAME_B);

        // ---- Instance B: one full frame, DE coverage and coordinate ranges
        cnt = 0;
        den_cyc = 0;
        max_h = 0;
        max_v = 0;
        do begin
            @(posedge clk); #1; cnt++;
            if (cnt == 1) chk("b_fs_one_cycle", 32'(fs_b), 0);
            if (den_b === 1'b1) den_cyc++;
            if (int'(hcnt_b) > max_h) max_h = int'(hcnt_b);
            if (int'(vcnt_b) > max_v) max_v = int'(vcnt_b);
        end while (fs_b !== 1'b1 && cnt < 2000);
        chk("b_frame_period", cnt, FRAME_B);
        chk("b_den_cycles", den_cyc, 8 * 4 * 4);
        chk("b_hcnt_max", max_h, 7);
        chk("b_vcnt_max", max_v, 3);

        // ---- Instance B: rgb capture with 3-clk source latency
        cnt = 0;
        while (den_b !== 1'b1 && cnt < 2000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("den_b_rise_seen", 32'(cnt < 2000), 1);
        for (int i = 0; i < 8; i++) begin
            chk("b_rgb_pixel", 32'(rgb_b), i);
            chk("b_den_pixel", 32'(den_b), 1);
            repeat (4) @(posedge clk);
            #1;
        end
        chk("b_den_after_line", 32'(den_b), 0);
        chk("b_rgb_after_line", 32'(rgb_b), 0);

        // ---- Instance B: asynchronous reset mid-active-line
        cnt = 0;
        while (!(hcnt_b === 10'd5 && vcnt_b === 10'd2) && cnt < 2000) begin
            @(posedge clk); #1; cnt++;
        end
        chk("b_reached_mid_line", 32'(cnt < 2000), 1);
        chk("b_den_before_reset", 32'(den_b), 1);
        #2;
        rst_b = 1'b1;
        #1;
        chk_rst("midrst_b", hcnt_b, vcnt_b, de_b, pclk_b, hs_b, vs_b, den_b, rgb_b, bl_b, fs_b);
        @(negedge clk);
        rst_b = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1; cnt++;
        end while (fs_b !== 1'b1 && cnt < 2000);
        chk("b_frame_start_after_midrst", cnt, FRAME_B);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
